ddr3_cmd_issuer: RTL and testbench

- Consumes one packed 32-bit controller command per handshake and drives the DDR3 command/address pins: PRECHARGE, ACTIVATE and READ/WRITE, spaced by programmable timing.
- Tracks the open row per bank, so row hits skip ACT and row conflicts insert PRE.
- Sits between the command queue (the producer of packed commands) and the PHY command pins.
- Emits a one-cycle rd/wr issue strobe that the data path uses to align read capture and write data.

---
 rtl/ddr3_cmd_issuer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ddr3_cmd_issuer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_issuer.sv
// ---------------------------------------------------------------------------
// ddr3_cmd_issuer
//   Takes one packed controller command per valid/ready handshake and plays it
//   onto the DDR3 command/address pins as PRECHARGE / ACTIVATE / READ-WRITE.
//   A per-bank open-row table decides whether the access is a row hit, a
//   closed-bank miss or a row conflict. A single down-counter provides the
//   ACT->RW, PRE->ACT and RW->next-accept spacing.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_in[31:0]          [31] r_w, [29:17] row, [15] BL8, [13] auto-precharge,
//                         [12:3] col, [2:0] bank; bits 30/16/14 reserved
//   ddr_cs_n..ddr_we_n    registered command pins
//   ddr_ba, ddr_addr      registered bank / address pins
//   rd_issue, wr_issue    one-cycle strobes aligned with RD / WR on the pins
//   busy                  inverse of cmd_ready
// ---------------------------------------------------------------------------
module ddr3_cmd_issuer #(
  parameter int T_RCD = 11,
  parameter int T_RP  = 11,
  parameter int T_GAP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_in,
  output logic        ddr_cs_n,
  output logic        ddr_ras_n,
  output logic        ddr_cas_n,
  output logic        ddr_we_n,
  output logic [2:0]  ddr_ba,
  output logic [13:0] ddr_addr,
  output logic        rd_issue,
  output logic        wr_issue,
  output logic        busy
);

  localparam int MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int MAX_T = (MAX_A > (T_GAP + T_RP)) ? MAX_A : (T_GAP + T_RP);
  localparam int CW    = $clog2(MAX_T + 1);

  // Counter reload values: loaded in the command cycle, a wait state exits
  // at 1, so a reload of 0 means the wait state is skipped entirely.
  localparam logic [CW-1:0] RCD_LD    = CW'(T_RCD - 1);
  localparam logic [CW-1:0] RP_LD     = CW'(T_RP - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(T_GAP - 1);
  localparam logic [CW-1:0] GAP_AP_LD = CW'(T_GAP + T_RP - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Reserved bits are masked off at accept time so they never reach the pins.
  localparam logic [31:0] RSVD_MASK = 32'hBFFE_BFFF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE      = 3'd1,
    S_WAIT_RP  = 3'd2,
    S_ACT      = 3'd3,
    S_WAIT_RCD = 3'd4,
    S_RW       = 3'd5,
    S_WAIT_GAP = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    cmd_q, cmd_d;
  logic [7:0]     open_q, open_d;
  logic [12:0]    row_q [8];
  logic [12:0]    row_d [8];

  logic           cs_n_q, cs_n_d, ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
  logic [2:0]     ba_q, ba_d;
  logic [13:0]    addr_q, addr_d;
  logic           rd_q, rd_d, wr_q, wr_d;

  logic           in_open_s, in_hit_s;

  assign in_open_s = open_q[cmd_in[2:0]];
  assign in_hit_s  = in_open_s && (row_q[cmd_in[2:0]] == cmd_in[29:17]);

  // Next-state, counter and command-latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d = cmd_in & RSVD_MASK;
          if (in_hit_s) begin
            state_d = S_RW;
          end else if (!in_open_s) begin
            state_d = S_ACT;
          end else begin
            state_d = S_PRE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        if (RP_LD == CNT_ZERO) begin
          state_d = S_ACT;
        end else begin
          state_d = S_WAIT_RP;
          cnt_d   = RP_LD;
        end
      end
      S_WAIT_RP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_ACT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ACT: begin
        if (RCD_LD == CNT_ZERO) begin
          state_d = S_RW;
        end else begin
          state_d = S_WAIT_RCD;
          cnt_d   = RCD_LD;
        end
      end
      S_WAIT_RCD: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_RW;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RW: begin
        // Auto-precharge adds the precharge recovery to the turnaround.
        if (cmd_q[13]) begin
          state_d = S_WAIT_GAP;
          cnt_d   = GAP_AP_LD;
        end else if (GAP_LD == CNT_ZERO) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_GAP;
          cnt_d   = GAP_LD;
        end
      end
      S_WAIT_GAP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Pin encoding: pins are registered from the next state so that the
  // command appears on the pins in the same cycle the FSM sits in that state.
  always_comb begin
    cs_n_d  = 1'b0;
    ras_n_d = 1'b1;
    cas_n_d = 1'b1;
    we_n_d  = 1'b1;
    ba_d    = ba_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_d)
      S_PRE: begin
        ras_n_d = 1'b0;
        we_n_d  = 1'b0;
        ba_d    = cmd_d[2:0];
        addr_d  = 14'h0000;
      end
      S_ACT: begin
        ras_n_d = 1'b0;
        ba_d    = cmd_d[2:0];
        addr_d  = {1'b0, cmd_d[29:17]};
      end
      S_RW: begin
        cas_n_d = 1'b0;
        we_n_d  = ~cmd_d[31];
        ba_d    = cmd_d[2:0];
        // A13=0, A12=burst length, A11=0, A10=auto-precharge, A9..A0=col
        addr_d  = {1'b0, cmd_d[15], 1'b0, cmd_d[13], cmd_d[12:3]};
        rd_d    = ~cmd_d[31];
        wr_d    = cmd_d[31];
      end
      default: begin
        cs_n_d = 1'b0;
      end
    endcase
  end

  // Open-row table maintenance driven by the command actually on the pins.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    case (state_q)
      S_ACT: begin
        open_d[cmd_q[2:0]] = 1'b1;
        row_d[cmd_q[2:0]]  = cmd_q[29:17];
      end
      S_PRE: begin
        open_d[cmd_q[2:0]] = 1'b0;
      end
      S_RW: begin
        if (cmd_q[13]) begin
          open_d[cmd_q[2:0]] = 1'b0;
        end else begin
          open_d[cmd_q[2:0]] = open_q[cmd_q[2:0]];
        end
      end
      default: begin
        open_d = open_q;
      end
    endcase
  end

  // State, counter, latched command and bank table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      cmd_q   <= 32'h0000_0000;
      open_q  <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        row_q[i] <= 13'h0000;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      open_q  <= open_d;
      row_q   <= row_d;
    end
  end

  // Registered DDR pins and issue strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q  <= 1'b1;
      ras_n_q <= 1'b1;
      cas_n_q <= 1'b1;
      we_n_q  <= 1'b1;
      ba_q    <= 3'd0;
      addr_q  <= 14'h0000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      cs_n_q  <= cs_n_d;
      ras_n_q <= ras_n_d;
      cas_n_q <= cas_n_d;
      we_n_q  <= we_n_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign ddr_cs_n  = cs_n_q;
  assign ddr_ras_n = ras_n_q;
  assign ddr_cas_n = cas_n_q;
  assign ddr_we_n  = we_n_q;
  assign ddr_ba    = ba_q;
  assign ddr_addr  = addr_q;
  assign rd_issue  = rd_q;
  assign wr_issue  = wr_q;

endmodule

// File: tb/tb_ddr3_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_ddr3_cmd_issuer
//   Directed bench for ddr3_cmd_issuer. u_dut runs with T_RCD=4, T_RP=3,
//   T_GAP=2; u_dut1 runs with all timings at 1. Pin values are sampled on the
//   falling edge, so a sample taken just before rising edge T+n is the value
//   "at T+n" where T is the accept edge.
// ---------------------------------------------------------------------------
module tb_ddr3_cmd_issuer;

  localparam logic [3:0] P_NOP = 4'b0111;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, busy;
  logic [31:0] cmd_in;
  logic        cs_n, ras_n, cas_n, we_n, rd_issue, wr_issue;
  logic [2:0]  ba;
  logic [13:0] addr;

  logic        cmd_valid1, cmd_ready1, busy1;
  logic [31:0] cmd_in1;
  logic        cs_n1, ras_n1, cas_n1, we_n1, rd_issue1, wr_issue1;
  logic [2:0]  ba1;
  logic [13:0] addr1;

  int n_checks;
  int n_errors;

  logic [3:0]  tr_pins [16];
  logic [2:0]  tr_ba   [16];
  logic [13:0] tr_addr [16];
  logic        tr_rd   [16];
  logic        tr_wr   [16];
  logic        tr_rdy  [16];
  logic        tr_busy [16];

  ddr3_cmd_issuer #(.T_RCD(4), .T_RP(3), .T_GAP(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in(cmd_in), .ddr_cs_n(cs_n), .ddr_ras_n(ras_n), .ddr_cas_n(cas_n),
    .ddr_we_n(we_n), .ddr_ba(ba), .ddr_addr(addr), .rd_issue(rd_issue),
    .wr_issue(wr_issue), .busy(busy)
  );

  ddr3_cmd_issuer #(.T_RCD(1), .T_RP(1), .T_GAP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_in(cmd_in1), .ddr_cs_n(cs_n1), .ddr_ras_n(ras_n1), .ddr_cas_n(cas_n1),
    .ddr_we_n(we_n1), .ddr_ba(ba1), .ddr_addr(addr1), .rd_issue(rd_issue1),
    .wr_issue(wr_issue1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic rw, input logic [12:0] row, input logic bl,
                                       input logic ap, input logic [9:0] col, input logic [2:0] bank);
    return {rw, 1'b0, row, 1'b0, bl, 1'b0, ap, col, bank};
  endfunction

  // Waits for ready, accepts one command on u_dut and records n cycles.
  task automatic issue(input logic [31:0] c, input int n);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    check_val("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_in    = c;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      cmd_valid   = 1'b0;
      tr_pins[i]  = {cs_n, ras_n, cas_n, we_n};
      tr_ba[i]    = ba;
      tr_addr[i]  = addr;
      tr_rd[i]    = rd_issue;
      tr_wr[i]    = wr_issue;
      tr_rdy[i]   = cmd_ready;
      tr_busy[i]  = busy;
    end
  endtask

  initial begin
    int acc, rdc, actc;
    n_checks   = 0;
    n_errors   = 0;
    cmd_valid  = 1'b0;
    cmd_in     = 32'h0;
    cmd_valid1 = 1'b0;
    cmd_in1    = 32'h0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_pins", {28'd0, cs_n, ras_n, cas_n, we_n}, 32'hF);
    check_val("rst_ba_addr", {15'd0, ba, addr}, 32'h0);
    check_val("rst_strobes", {30'd0, rd_issue, wr_issue}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ready_busy", {30'd0, cmd_ready, busy}, 32'h2);

    // 1: closed bank READ, ACT at T+1, RD at T+5, ready at T+7
    issue(pack(1'b0, 13'h0155, 1'b1, 1'b0, 10'h010, 3'd2), 7);
    check_val("t1_act_pins", {28'd0, tr_pins[1]}, {28'd0, P_ACT});
    check_val("t1_act_ba_addr", {15'd0, tr_ba[1], tr_addr[1]}, {15'd0, 3'd2, 14'h0155});
    check_val("t1_nop_t2_t4", {20'd0, tr_pins[2], tr_pins[3], tr_pins[4]}, {20'd0, P_NOP, P_NOP, P_NOP});
    check_val("t1_rd_pins", {28'd0, tr_pins[5]}, {28'd0, P_RD});
    check_val("t1_rd_addr", {18'd0, tr_addr[5]}, 32'h1010);
    check_val("t1_rd_issue", {28'd0, tr_rd[4], tr_rd[5], tr_rd[6], tr_wr[5]}, 32'h4);
    check_val("t1_ready_t6_t7", {30'd0, tr_rdy[6], tr_rdy[7]}, 32'h1);
    check_val("t1_busy_t1", {31'd0, tr_busy[1]}, 32'd1);

    // 2: row hit WRITE, WR at T+1, ready at T+3
    issue(pack(1'b1, 13'h0155, 1'b0, 1'b0, 10'h3FF, 3'd2), 3);
    check_val("t2_wr_pins", {28'd0, tr_pins[1]}, {28'd0, P_WR});
    check_val("t2_wr_ba_addr", {15'd0, tr_ba[1], tr_addr[1]}, {15'd0, 3'd2, 14'h03FF});
    check_val("t2_wr_issue", {30'd0, tr_wr[1], tr_rd[1]}, 32'h2);
    check_val("t2_ready_t2_t3", {30'd0, tr_rdy[2], tr_rdy[3]}, 32'h1);

    // 3: row conflict, PRE at T+1, ACT at T+4, RD at T+8
    issue(pack(1'b0, 13'h1FFF, 1'b0, 1'b0, 10'h055, 3'd2), 10);
    check_val("t3_pre_pins", {28'd0, tr_pins[1]}, {28'd0, P_PRE});
    check_val("t3_pre_ba_addr", {15'd0, tr_ba[1], tr_addr[1]}, {15'd0, 3'd2, 14'h0000});
    check_val("t3_nop_t2_t3", {24'd0, tr_pins[2], tr_pins[3]}, {24'd0, P_NOP, P_NOP});
    check_val("t3_act", {14'd0, tr_pins[4], tr_addr[4]}, {14'd0, P_ACT, 14'h1FFF});
    check_val("t3_nop_t7", {28'd0, tr_pins[7]}, {28'd0, P_NOP});
    check_val("t3_rd", {13'd0, tr_rd[8], tr_pins[8], tr_addr[8]}, {13'd0, 1'b1, P_RD, 14'h0055});
    check_val("t3_ready_t9_t10", {30'd0, tr_rdy[9], tr_rdy[10]}, 32'h1);

    // 4: auto-precharge READ on bank 5, ready at RW+5, then bank 5 is closed
    issue(pack(1'b0, 13'h0AAA, 1'b1, 1'b1, 10'h001, 3'd5), 10);
    check_val("t4_act", {14'd0, tr_pins[1], tr_addr[1]}, {14'd0, P_ACT, 14'h0AAA});
    check_val("t4_rd_ap", {11'd0, tr_pins[5], tr_ba[5], tr_addr[5]}, {11'd0, P_RD, 3'd5, 14'h1401});
    check_val("t4_ready_t9_t10", {30'd0, tr_rdy[9], tr_rdy[10]}, 32'h1);
    issue(pack(1'b0, 13'h0AAA, 1'b1, 1'b0, 10'h002, 3'd5), 1);
    check_val("t4_reopen_act", {28'd0, tr_pins[1]}, {28'd0, P_ACT});

    // 5: all timings 1 with cmd_valid held high on u_dut1
    acc  = 0;
    rdc  = 0;
    actc = 0;
    @(negedge clk);
    cmd_in1    = pack(1'b0, 13'h0042, 1'b1, 1'b0, 10'h008, 3'd1);
    cmd_valid1 = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 12) cmd_valid1 = 1'b0;
      if (cmd_valid1 && cmd_ready1) acc++;
      if (rd_issue1) rdc++;
      if ({cs_n1, ras_n1, cas_n1, we_n1} == P_ACT) actc++;
      if (k == 1) check_val("t5_act_t1", {28'd0, cs_n1, ras_n1, cas_n1, we_n1}, {28'd0, P_ACT});
      if (k == 2) check_val("t5_rd_t2", {26'd0, rd_issue1, cmd_ready1, cs_n1, ras_n1, cas_n1, we_n1},
                            {26'd0, 1'b1, 1'b0, P_RD});
      if (k == 3) check_val("t5_ready_t3", {31'd0, cmd_ready1}, 32'd1);
      @(negedge clk);
    end
    check_val("t5_accepts", acc, 32'd6);
    check_val("t5_rd_pulses", rdc, 32'd6);
    check_val("t5_act_count", actc, 32'd1);

    // 6: asynchronous reset one cycle after ACT
    issue(pack(1'b0, 13'h0123, 1'b1, 1'b0, 10'h004, 3'd3), 1);
    check_val("t6_act", {11'd0, tr_pins[1], tr_ba[1], tr_addr[1]}, {11'd0, P_ACT, 3'd3, 14'h0123});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_pins", {28'd0, cs_n, ras_n, cas_n, we_n}, 32'hF);
    check_val("t6_async_ba_addr", {15'd0, ba, addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(pack(1'b0, 13'h0123, 1'b1, 1'b0, 10'h004, 3'd3), 5);
    check_val("t6_miss_act", {28'd0, tr_pins[1]}, {28'd0, P_ACT});
    check_val("t6_rd_t5", {27'd0, tr_rd[5], tr_pins[5]}, {27'd0, 1'b1, P_RD});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
